// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM encodings, RCON and the byte/column helpers
// used by both the encryptor and the decryptor datapaths.
package aes_pkg;

   localparam int NR_128 = 10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } aes_state_e;

   // RCON[1..10]; any other round index yields 0 and is never used by the datapath.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = c;
      return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
              b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
              b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
              xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   // Byte k sits at [127-8k -: 8] with k = row + 4*col; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      return o;
   endfunction

   // One key-schedule step; sw is SubWord(RotWord(w3)) computed by the caller's S-boxes.
   function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [31:0] sw,
                                             input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = rk[127:96] ^ sw ^ {rc, 24'h000000};
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
module aes_sbox (
   input  logic [7:0] sbox_in,
   output logic [7:0] sbox_out
);

   // Entry 0 occupies the top byte, so entry n lives at bit offset 8*(255-n).
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign sbox_out = SBOX_TBL[{~sbox_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_encryptor_iter.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Define AES_ENC_PIPE_SBOX_EN to register after SubBytes, giving two cycles per round.
module aes_encryptor_iter
   import aes_pkg::*;
#(
   parameter int NR          = 10,
   parameter bit RST_CLR_DAT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plain_text,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] cipher_text,
   output logic         busy
);

   localparam logic [3:0] NR_L = 4'(NR);

   if (NR != NR_128) begin : g_nr_check
      $error("aes_encryptor_iter: only NR=10 (AES-128) is supported");
   end

   aes_state_e   state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] st_q, st_d;
   logic [127:0] rk_q, rk_d;
   logic [127:0] ct_q, ct_d;

   logic [127:0] sb_st;
   logic [31:0]  rot_w, sb_w;
   logic [127:0] sr_in, sr, rk_next, round_out;
   logic [31:0]  sw_use;
   logic         last_rnd, step;

   assign rot_w = {rk_q[23:0], rk_q[31:24]};

   for (genvar i = 0; i < 16; i++) begin : g_sb_st
      aes_sbox u_sbox (.sbox_in(st_q[127-8*i -: 8]), .sbox_out(sb_st[127-8*i -: 8]));
   end

   for (genvar i = 0; i < 4; i++) begin : g_sb_w
      aes_sbox u_sbox (.sbox_in(rot_w[31-8*i -: 8]), .sbox_out(sb_w[31-8*i -: 8]));
   end

`ifdef AES_ENC_PIPE_SBOX_EN
   // Phase 0 parks SubBytes(st) in st_q and SubWord in sw_q; phase 1 finishes the round.
   logic        phase_q, phase_d;
   logic [31:0] sw_q, sw_d;

   assign sr_in  = st_q;
   assign sw_use = sw_q;
   assign step   = phase_q;
`else
   assign sr_in  = sb_st;
   assign sw_use = sb_w;
   assign step   = 1'b1;
`endif

   assign last_rnd  = (round_q == NR_L);
   assign rk_next   = key_step(rk_q, sw_use, rcon(round_q));
   assign sr        = shift_rows(sr_in);
   assign round_out = (last_rnd ? sr : mix_columns(sr)) ^ rk_next;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      st_d    = st_q;
      rk_d    = rk_q;
      ct_d    = ct_q;
`ifdef AES_ENC_PIPE_SBOX_EN
      phase_d = phase_q;
      sw_d    = sw_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               st_d    = plain_text ^ key_in;
               rk_d    = key_in;
               round_d = 4'd1;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
`ifdef AES_ENC_PIPE_SBOX_EN
            phase_d = ~phase_q;
            if (!phase_q) begin
               st_d = sb_st;
               sw_d = sb_w;
            end
`endif
            if (step) begin
               st_d = round_out;
               rk_d = rk_next;
               if (last_rnd) begin
                  ct_d    = round_out;
                  round_d = 4'd0;
                  state_d = S_DONE;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         round_q <= 4'd0;
`ifdef AES_ENC_PIPE_SBOX_EN
         phase_q <= 1'b0;
         sw_q    <= 32'h0;
`endif
      end else begin
         state_q <= state_d;
         round_q <= round_d;
`ifdef AES_ENC_PIPE_SBOX_EN
         phase_q <= phase_d;
         sw_q    <= sw_d;
`endif
      end
   end

   if (RST_CLR_DAT) begin : g_dat_rst
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            st_q <= '0;
            rk_q <= '0;
            ct_q <= '0;
         end else begin
            st_q <= st_d;
            rk_q <= rk_d;
            ct_q <= ct_d;
         end
      end
   end else begin : g_dat_norst
      // NOTE: wide datapath left unreset; the FSM never lets its contents escape before a load.
      always_ff @(posedge clk) begin
         st_q <= st_d;
         rk_q <= rk_d;
         ct_q <= ct_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign cipher_text = ct_q;

endmodule

// File: tb/tb_aes_encryptor_iter.sv
// Directed bench for aes_encryptor_iter: FIPS-197 vectors, latency, backpressure, mid-op reset.
module tb_aes_encryptor_iter;

`ifdef AES_ENC_PIPE_SBOX_EN
   localparam int LAT = 20;
`else
   localparam int LAT = 10;
`endif

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plain_text;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] cipher_text;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_encryptor_iter #(.NR(10), .RST_CLR_DAT(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .plain_text  (plain_text),
      .key_in      (key_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .cipher_text (cipher_text),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Presents one block, returns at the falling edge after the accepting rising edge.
   task automatic start_block(input string tag, input logic [127:0] pt, input logic [127:0] key);
      int w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_in_ready_wait"}, in_ready, 1'b1);
      in_valid   = 1'b1;
      plain_text = pt;
      key_in     = key;
      @(posedge clk);
      @(negedge clk);
      in_valid   = 1'b0;
      plain_text = ~pt;
      key_in     = ~key;
      check({tag, "_busy_after_accept"}, busy, 1'b1);
      check({tag, "_in_ready_low"}, in_ready, 1'b0);
   endtask

   task automatic wait_done(input string tag, input logic [127:0] exp);
      int n = 0;
      while (!out_valid && n < LAT + 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check({tag, "_latency"}, n, LAT);
      check({tag, "_cipher"}, cipher_text, exp);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_out_valid_cleared"}, out_valid, 1'b0);
      check({tag, "_in_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      int viol;
      int seen;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      plain_text = '0;
      key_in     = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cipher", cipher_text, '0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);

      start_block("appb", PT_B, KEY_B);
      wait_done("appb", CT_B);
      handshake("appb");

      start_block("appc", PT_C, KEY_C);
      wait_done("appc", CT_C);
      handshake("appc");

      start_block("zero", '0, '0);
      wait_done("zero", CT_Z);
      handshake("zero");

      // Backpressure with a competing block presented throughout.
      out_ready = 1'b0;
      start_block("bp", PT_C, KEY_C);
      wait_done("bp", CT_C);
      in_valid   = 1'b1;
      plain_text = PT_B;
      key_in     = KEY_B;
      viol       = 0;
      repeat (50) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || cipher_text !== CT_C || in_ready || !busy) viol++;
      end
      check("bp_stable", viol, 0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready", in_ready, 1'b1);
      check("bp_no_same_cycle_accept", busy, 1'b0);
      check("bp_release_out_valid", out_valid, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);

      // Reset pulse around round 5 discards the block.
      start_block("rstmid", PT_B, KEY_B);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_in_ready", in_ready, 1'b1);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_cipher_cleared", cipher_text, '0);
      seen = 0;
      repeat (25) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rstmid_no_out_valid", seen, 0);

      start_block("appb2", PT_B, KEY_B);
      wait_done("appb2", CT_B);
      handshake("appb2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
